// File: rtl/run_controller_if.sv
// Host/processor handshake bundle for run_controller.
// master drives requests and halt; slave is the controller.
interface run_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        start;
  logic        halt;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_cycles;
  logic        res_timeout;
  logic        busy;

  modport master (
    output cmd_valid, halt, res_ready,
    input  cmd_ready, start, res_valid,
    input  res_cycles, res_timeout, busy
  );

  modport slave (
    input  cmd_valid, halt, res_ready,
    output cmd_ready, start, res_valid,
    output res_cycles, res_timeout, busy
  );
endinterface

// File: rtl/run_controller.sv
// Sequences one processor run: start pulse, cycle count, result handshake.
// Optional RUN-cycle timeout: define RUN_CONTROLLER_TIMEOUT_EN.
module run_controller #(
  parameter int unsigned START_CYCLES   = 2,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input logic         clk,
  input logic         reset,
  run_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_START = 4'(START_CYCLES);

`ifdef RUN_CONTROLLER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  state_t      r_state;
  logic [3:0]  r_scnt;
  logic [31:0] r_cycles;
  logic        r_timeout;
  logic        r_cmd_ready;
  logic        r_start;
  logic        r_busy;
  logic        r_res_valid;

  logic [31:0] w_cyc_inc;
  logic        w_tmo_hit;

  // Count saturates rather than wrapping.
  assign w_cyc_inc = (&r_cycles) ? r_cycles
                                 : r_cycles + 32'd1;
  assign w_tmo_hit = TMO_EN &&
                     (w_cyc_inc >= TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_scnt      <= '0;
      r_cycles    <= '0;
      r_timeout   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_start     <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_state     <= S_START;
            r_scnt      <= LP_START;
            r_cycles    <= '0;
            r_timeout   <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        // halt is meaningless while the core is held in reset
        S_START: begin
          if (r_scnt <= 4'd1) begin
            r_state <= S_RUN;
            r_scnt  <= '0;
            r_start <= 1'b0;
          end else begin
            r_scnt <= r_scnt - 4'd1;
          end
        end
        S_RUN: begin
          if (bus.halt) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b1;
          end else begin
            r_cycles <= w_cyc_inc;
            if (w_tmo_hit) begin
              r_state     <= S_DONE;
              r_timeout   <= 1'b1;
              r_busy      <= 1'b0;
              r_res_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_start     <= 1'b0;
          r_busy      <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.start       = r_start;
  assign bus.busy        = r_busy;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_cycles  = r_cycles;
  assign bus.res_timeout = r_timeout;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: vector table,
// directed corner sequences and a randomized model comparison.
module tb_run_controller;

  localparam int unsigned SC = 2;
  localparam logic [31:0] TO = 32'd20;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  run_controller_if bus ();

  run_controller #(
    .START_CYCLES  (SC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv, h, rr;
    logic        ecr, est, ebusy, erv;
    logic [31:0] ecyc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic cv, h, rr, ecr, est, ebusy, erv,
    input logic [31:0] ecyc);
    vec_t v;
    v.cv = cv; v.h = h; v.rr = rr;
    v.ecr = ecr; v.est = est;
    v.ebusy = ebusy; v.erv = erv; v.ecyc = ecyc;
    vq.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic ecr, est, ebusy, erv,
                         input logic [31:0] ecyc,
                         input logic eto);
    chk({nm, ".cmd_ready"}, 32'(bus.cmd_ready), 32'(ecr));
    chk({nm, ".start"}, 32'(bus.start), 32'(est));
    chk({nm, ".busy"}, 32'(bus.busy), 32'(ebusy));
    chk({nm, ".res_valid"}, 32'(bus.res_valid), 32'(erv));
    chk({nm, ".res_cycles"}, bus.res_cycles, ecyc);
    chk({nm, ".res_timeout"}, 32'(bus.res_timeout), 32'(eto));
  endtask

  task automatic drive(input logic cv, h, rr);
    bus.cmd_valid = cv;
    bus.halt      = h;
    bus.res_ready = rr;
  endtask

  // Reference model: phase 0 idle, 1 starting, 2 running, 3 result.
  int          m_ph;
  int          m_left;
  logic [31:0] m_cyc;
  logic        m_to;
  bit          tmo_en;

  task automatic model_edge(input logic rst, cv, h, rr);
    if (rst) begin
      m_ph = 0; m_left = 0; m_cyc = 0; m_to = 0;
    end else if (m_ph == 0) begin
      if (cv) begin
        m_ph = 1; m_left = SC; m_cyc = 0; m_to = 0;
      end
    end else if (m_ph == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_ph = 2;
    end else if (m_ph == 2) begin
      if (h) m_ph = 3;
      else begin
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (tmo_en && m_cyc >= TO) begin
          m_ph = 3; m_to = 1;
        end
      end
    end else begin
      if (rr) m_ph = 0;
    end
  endtask

  initial begin
    int k;
`ifdef RUN_CONTROLLER_TIMEOUT_EN
    tmo_en = 1'b1;
`else
    tmo_en = 1'b0;
`endif
    reset = 1'b1;
    drive(0, 0, 0);
    step();
    chk_all("reset", 1, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Basic run of 10 cycles, then 5 cycles of backpressure.
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 10; i++)
      add(0, 0, 0, 0, 0, 1, 0, i);
    add(0, 1, 0, 0, 0, 0, 1, 10);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 0, 0, 1, 10);
    add(0, 0, 1, 1, 0, 0, 0, 10);
    // Halt high through START is ignored; halts on first RUN cycle.
    add(1, 1, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].cv, vq[i].h, vq[i].rr);
      step();
      chk_all($sformatf("vec%0d", i), vq[i].ecr, vq[i].est,
              vq[i].ebusy, vq[i].erv, vq[i].ecyc, 1'b0);
    end

    // Reset at RUN cycle 5.
    drive(1, 0, 0); step();
    drive(0, 0, 0); step(); step();
    for (int i = 0; i < 5; i++) step();
    chk_all("mid_run5", 0, 0, 1, 0, 5, 0);
    reset = 1'b1; step();
    chk_all("rst_run", 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    // Reset during START.
    drive(1, 0, 0); step();
    chk_all("start_again", 0, 1, 1, 0, 0, 0);
    reset = 1'b1; drive(0, 0, 0); step();
    chk_all("rst_start", 1, 0, 0, 0, 0, 0);
    reset = 1'b0;
    // Fresh run counts from zero.
    drive(1, 0, 0); step();
    drive(0, 0, 0); step(); step();
    for (int i = 0; i < 3; i++) step();
    drive(0, 1, 0); step();
    chk_all("rerun_done", 0, 0, 0, 1, 3, 0);
    drive(0, 0, 1); step();
    chk_all("rerun_idle", 1, 0, 0, 0, 3, 0);

    // Timeout behaviour with halt held low.
    drive(1, 0, 0); step();
    drive(0, 0, 0); step(); step();
`ifdef RUN_CONTROLLER_TIMEOUT_EN
    k = 0;
    while (!bus.res_valid && k < 60) begin
      step(); k++;
    end
    chk("tmo_edges", k, 20);
    chk_all("tmo_done", 0, 0, 0, 1, TO, 1);
    drive(0, 0, 1); step();
    chk_all("tmo_idle", 1, 0, 0, 0, TO, 1);
    // Halt on the would-be timeout cycle wins.
    drive(1, 0, 0); step();
    chk_all("prec_start", 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0); step(); step();
    for (int i = 0; i < 19; i++) step();
    drive(0, 1, 0); step();
    chk_all("prec_done", 0, 0, 0, 1, 19, 0);
    drive(0, 0, 1); step();
`else
    k = 0;
    for (int i = 0; i < 100; i++) begin
      step(); k++;
    end
    chk("notmo_edges", k, 100);
    chk_all("notmo_run", 0, 0, 1, 0, 100, 0);
    reset = 1'b1; step();
    reset = 1'b0;
`endif

    // Back-to-back: cmd_valid and res_ready held high.
    drive(1, 0, 1); step();
    chk_all("b2b_s1", 0, 1, 1, 0, 0, 0);
    step(); step();
    for (int i = 0; i < 4; i++) step();
    bus.halt = 1'b1; step();
    chk_all("b2b_r1", 0, 0, 0, 1, 4, 0);
    bus.halt = 1'b0; step();
    chk_all("b2b_hs1", 1, 0, 0, 0, 4, 0);
    step();
    chk_all("b2b_s2", 0, 1, 1, 0, 0, 0);
    step(); step();
    for (int i = 0; i < 2; i++) step();
    bus.halt = 1'b1; step();
    chk_all("b2b_r2", 0, 0, 0, 1, 2, 0);
    drive(0, 0, 1); step();
    chk_all("b2b_end", 1, 0, 0, 0, 2, 0);

    // Randomized traffic against the model.
    reset = 1'b1;
    model_edge(1, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic rr_, cv_, h_, rs_;
      rs_ = ($urandom_range(0, 79) == 0);
      cv_ = $urandom_range(0, 1) == 1;
      h_  = ($urandom_range(0, 7) == 0);
      rr_ = $urandom_range(0, 1) == 1;
      reset = rs_;
      drive(cv_, h_, rr_);
      model_edge(rs_, cv_, h_, rr_);
      step();
      chk_all($sformatf("rnd%0d", i),
              m_ph == 0, m_ph == 1,
              (m_ph == 1) || (m_ph == 2),
              m_ph == 3, m_cyc, m_to);
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
